// File: rtl/stream_pkg.sv
// Shared stream definitions for the serializer/sink pair: the receive FSM
// state type, the counter-width derivation and the MSB-first slot mapping.
package stream_pkg;

  // Receive-side FSM states. DISCARD is only reachable when protocol error
  // checking is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } stream_state_e;

  // Width needed to hold a word count in the range 0..max_length.
  function automatic int len_w(input int max_length);
    return $clog2(max_length + 1);
  endfunction

  // Slot occupied by the word at position pos (0 = sop word) of a packet.
  // Words travel MSB-first, so the first word owns the top slot.
  function automatic int word_slot(input int max_length, input int pos);
    return max_length - 1 - pos;
  endfunction

endpackage

// File: rtl/stream_sink.sv
// stream_sink: reassembles a valid/sop/eop word stream into one parallel
// vector and presents it with a single-cycle out_valid pulse.
// Optional feature macro: STREAM_SINK_ERR_CHECK_EN enables the error output,
// the DISCARD state and dropping of overlong packets. Without it, protocol
// violations are absorbed silently and overlong packets are truncated.
module stream_sink
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LENGTH = 16,
  localparam int LEN_W = len_w(MAX_LENGTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid,
  input  logic                             sop,
  input  logic                             eop,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic [MAX_LENGTH*DATA_WIDTH-1:0] data_out,
  output logic                             out_valid,
  output logic [LEN_W-1:0]                 length,
  output logic                             error
);

  localparam int VEC_W = MAX_LENGTH * DATA_WIDTH;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LENGTH);
  localparam logic [LEN_W-1:0] ONE_CNT = LEN_W'(1);

`ifdef STREAM_SINK_ERR_CHECK_EN
  localparam bit ERR_CHECK = 1'b1;
`else
  localparam bit ERR_CHECK = 1'b0;
`endif

  stream_state_e     state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [VEC_W-1:0]  asm_q, asm_d;
  logic [VEC_W-1:0]  data_out_q, data_out_d;
  logic [LEN_W-1:0]  length_q, length_d;
  logic              out_valid_q, out_valid_d;
  logic              error_q, error_d;

  logic              cnt_full;
  logic [VEC_W-1:0]  merged;
  logic [VEC_W-1:0]  first_vec;
  logic [LEN_W-1:0]  len_next;
  logic              take_sop;

  assign cnt_full = (cnt_q == MAX_CNT);

  // Candidate vectors: the buffer with the current word written at the next
  // slot, and a fresh buffer holding only the current word as a first word.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    merged    = asm_q;
    first_vec = '0;
    if (!cnt_full) begin
      merged[word_slot(MAX_LENGTH, int'(cnt_q)) * DATA_WIDTH +: DATA_WIDTH] = data_in;
    end
    first_vec[word_slot(MAX_LENGTH, 0) * DATA_WIDTH +: DATA_WIDTH] = data_in;
    // A word arriving with the buffer already full is dropped, so the length
    // saturates at MAX_LENGTH.
    len_next = cnt_full ? MAX_CNT : (cnt_q + ONE_CNT);
  end

  // Next-state logic: FSM transitions, buffer writes and completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    data_out_d  = data_out_q;
    length_d    = length_q;
    out_valid_d = 1'b0;
    error_d     = 1'b0;
    take_sop    = 1'b0;

    if (valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (sop) begin
            take_sop = 1'b1;
          end else begin
            // Stray word outside a packet: dropped.
            error_d = ERR_CHECK;
          end
        end

        ST_RECV: begin
          if (sop) begin
            // A new sop abandons the packet in progress.
            take_sop = 1'b1;
            error_d  = ERR_CHECK;
          end else if (eop) begin
            data_out_d  = merged;
            length_d    = len_next;
            out_valid_d = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end else if (!cnt_full) begin
            asm_d = merged;
            cnt_d = cnt_q + ONE_CNT;
          end else begin
`ifdef STREAM_SINK_ERR_CHECK_EN
            // Overlong packet: flag it and throw the rest away up to eop.
            error_d = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
            state_d = ST_DISCARD;
`endif
            // Without error checking the extra word is simply dropped and
            // the packet still completes on eop.
          end
        end

`ifdef STREAM_SINK_ERR_CHECK_EN
        ST_DISCARD: begin
          if (sop) begin
            take_sop = 1'b1;
          end else if (eop) begin
            state_d = ST_IDLE;
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          asm_d   = '0;
        end
      endcase
    end

    // Shared start-of-packet handling for IDLE, DISCARD and restart in RECV.
    // A sop that is also eop is a complete one-word packet.
    if (take_sop) begin
      if (eop) begin
        data_out_d  = first_vec;
        length_d    = ONE_CNT;
        out_valid_d = 1'b1;
        asm_d       = '0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end else begin
        asm_d   = first_vec;
        cnt_d   = ONE_CNT;
        state_d = ST_RECV;
      end
    end
  end

  // State registers with synchronous reset; the assembly buffer is cleared
  // too so a packet aborted by reset can never leak into a later one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      data_out_q  <= '0;
      length_q    <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      data_out_q  <= data_out_d;
      length_q    <= length_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  assign data_out  = data_out_q;
  assign length    = length_q;
  assign out_valid = out_valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_stream_sink.sv
// Self-checking bench for stream_sink (DATA_WIDTH=8, MAX_LENGTH=4).
// Directed packets followed by random per-cycle stimulus, all compared
// against a packet-level queue model. Honours STREAM_SINK_ERR_CHECK_EN.
module tb_stream_sink;

  localparam int W   = 8;
  localparam int MAX = 4;
  localparam int LW  = $clog2(MAX + 1);

`ifdef STREAM_SINK_ERR_CHECK_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              valid;
  logic              sop;
  logic              eop;
  logic [W-1:0]      data_in;
  logic [MAX*W-1:0]  data_out;
  logic              out_valid;
  logic [LW-1:0]     length;
  logic              error;

  stream_sink #(
    .DATA_WIDTH(W),
    .MAX_LENGTH(MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .sop      (sop),
    .eop      (eop),
    .data_in  (data_in),
    .data_out (data_out),
    .out_valid(out_valid),
    .length   (length),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packet-level model: words of the packet in progress are kept in a queue;
  // a packet is either open, being thrown away, or absent.
  logic [W-1:0]     words[$];
  bit               in_pkt;
  bit               discarding;
  logic [MAX*W-1:0] exp_data;
  int               exp_len;
  bit               exp_ov;
  bit               exp_err;

  task automatic model_reset();
    words.delete();
    in_pkt     = 1'b0;
    discarding = 1'b0;
    exp_data   = '0;
    exp_len    = 0;
    exp_ov     = 1'b0;
    exp_err    = 1'b0;
  endtask

  task automatic model_finish();
    logic [MAX*W-1:0] v;
    v = '0;
    foreach (words[i]) v[(MAX - 1 - i) * W +: W] = words[i];
    exp_data = v;
    exp_len  = words.size();
    exp_ov   = 1'b1;
    in_pkt   = 1'b0;
    words.delete();
  endtask

  task automatic model_beat(input bit v, input bit s, input bit e, input logic [W-1:0] d);
    exp_ov  = 1'b0;
    exp_err = 1'b0;
    if (!v) return;
    if (s) begin
      if (in_pkt && ERR) exp_err = 1'b1;
      words.delete();
      words.push_back(d);
      in_pkt     = 1'b1;
      discarding = 1'b0;
      if (e) model_finish();
    end else if (!in_pkt) begin
      if (discarding) begin
        if (e) discarding = 1'b0;
      end else if (ERR) begin
        exp_err = 1'b1;
      end
    end else if (e) begin
      if (words.size() < MAX) words.push_back(d);
      model_finish();
    end else if (words.size() < MAX) begin
      words.push_back(d);
    end else if (ERR) begin
      exp_err    = 1'b1;
      in_pkt     = 1'b0;
      discarding = 1'b1;
      words.delete();
    end
  endtask

  // One clock cycle: drive at the falling edge, let the rising edge sample,
  // then compare every output at the next falling edge.
  task automatic beat(input bit r, input bit v, input bit s, input bit e, input logic [W-1:0] d);
    reset   = r;
    valid   = v;
    sop     = s;
    eop     = e;
    data_in = d;
    @(posedge clk);
    if (r) model_reset();
    else   model_beat(v, s, e, d);
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("error",     64'(error),     64'(exp_err));
    check("data_out",  64'(data_out),  64'(exp_data));
    check("length",    64'(length),    64'(exp_len));
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, 1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    model_reset();
    reset = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; data_in = '0;
    @(negedge clk);

    beat(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    beat(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    check("rst_data", 64'(data_out), 64'h0);
    check("rst_len",  64'(length),   64'h0);
    idle();

    // Full-length packet, back-to-back words.
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'h44);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'h11);
    check("full_data", 64'(data_out),  64'h44332211);
    check("full_len",  64'(length),    64'd4);
    check("full_ov",   64'(out_valid), 64'd1);
    idle();
    check("full_pulse", 64'(out_valid), 64'd0);
    check("full_hold",  64'(data_out),  64'h44332211);

    // Two words with gaps, then immediately a one-word packet (eop -> sop).
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    idle();
    idle();
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'hBB);
    check("gap_data", 64'(data_out), 64'hAABB0000);
    check("gap_len",  64'(length),   64'd2);
    beat(1'b0, 1'b1, 1'b1, 1'b1, 8'h5C);
    check("one_data", 64'(data_out), 64'h5C000000);
    check("one_len",  64'(length),   64'd1);
    check("one_err",  64'(error),    64'd0);

    // Overlong packet, then a normal one.
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'hC0);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hC1);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hC2);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hC3);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hC4);
    check("ovf_err", 64'(error), 64'(ERR));
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hC5);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'hC6);
    check("ovf_ov", 64'(out_valid), 64'(!ERR));
    if (!ERR) check("ovf_trunc", 64'(data_out), 64'hC0C1C2C3);
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'hD0);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'hD1);
    check("after_ovf", 64'(data_out), 64'hD0D10000);

    // Restart with a second sop mid-packet.
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'h90);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h91);
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    check("rst_sop_err", 64'(error), 64'(ERR));
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
    check("restart_data", 64'(data_out), 64'h77010200);
    check("restart_len",  64'(length),   64'd3);

    // Stray word outside a packet.
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h3E);
    check("stray_err", 64'(error), 64'(ERR));

    // Reset in the middle of a packet, then a full packet.
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'h12);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'h34);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'h56);
    check("abort_ov", 64'(out_valid), 64'd0);
    beat(1'b0, 1'b1, 1'b1, 1'b0, 8'hA1);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 8'hA3);
    beat(1'b0, 1'b1, 1'b0, 1'b1, 8'hA4);
    check("post_rst_data", 64'(data_out), 64'hA1A2A3A4);

    // Random per-cycle stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      beat(($urandom_range(0, 96) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0),
           W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_sink.md
# stream_sink

Receive-side counterpart of the packet serializer `src`. It consumes a valid/sop/eop word stream and reassembles each packet into one parallel vector. Once the packet completes, it presents that vector for a single cycle. It sits downstream of the serializer or any equivalent stream source and feeds parallel consumers such as the sorter under test.

## Interface
- `DATA_WIDTH`, 8: bits per stream word.
- `MAX_LENGTH`, 16: maximum words per packet; width of the parallel output in words.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid`  in  1  stream word qualifier.
- `sop`  in  1  first word of packet, qualified by `valid`.
- `eop`  in  1  last word of packet, qualified by `valid`.
- `data_in`  in  DATA_WIDTH  stream word.
- `data_out`  out  MAX_LENGTH*DATA_WIDTH  assembled packet. Word k sits at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `out_valid`  out  1  one-cycle pulse when `data_out`/`length` hold a new packet.
- `length`  out  LEN_W = $clog2(MAX_LENGTH+1)  number of words in the presented packet.
- `error`  out  1  one-cycle protocol-error pulse.

## Operation
- Word order is MSB-first, matching the serializer:
  - the sop word lands in slot MAX_LENGTH-1;
  - each following word lands one slot lower;
  - a full packet's eop word lands in slot 0.
  - A full-length packet therefore reproduces the serializer's `data_in` exactly.
- Short packets are left-aligned. Unfilled low slots read 0.
- Beats with `valid`=0 are ignored in every state. Gaps inside a packet are legal.
- FSM states:
  - IDLE:
    - `valid&sop&eop`: one-word packet, complete immediately.
    - `valid&sop`: clear the assembly buffer, write the word, go to RECV.
    - `valid&!sop`: word dropped, `error` pulse, stay in IDLE.
  - RECV:
    - `valid&sop`: restart. Pulse `error`, clear the buffer, write the word as a new first word, stay in RECV.
    - `valid&eop`: write the word, complete, go to IDLE.
    - `valid` otherwise: write the word. Word count is checked for overflow (below).
  - DISCARD:
    - All words are dropped.
    - `valid&eop` goes to IDLE with no completion.
    - `valid&sop` starts a new packet as in IDLE.
- Word counter `cnt` is LEN_W bits. It counts words accepted in the current packet.
- Overflow: a non-eop word arriving with `cnt`==MAX_LENGTH pulses `error` and goes to DISCARD. The partial packet is never presented.
- Completion: copy the assembly buffer plus the current word into the `data_out` register, set `length` = `cnt`+1, pulse `out_valid`.
- `data_out` and `length` hold until the next completion.

## Timing
- Reset values: `data_out`=0, `length`=0, `out_valid`=0, `error`=0, state IDLE, `cnt`=0, assembly buffer 0.
- Latency: `out_valid` is high in the cycle after the eop beat is sampled. All outputs are registered.
- `error` is high in the cycle after the offending beat is sampled.
- Back-to-back packets are supported at full rate. An eop beat followed by a sop beat on the next cycle loses no word and raises no error.
- `out_valid` and `error` never assert in the same cycle, except on a restart sop arriving with `eop` also set. In that case both pulse and the new one-word packet is presented.
- Reset asserted mid-packet discards the partial packet. No `out_valid` is produced for it.

## Configuration
- `STREAM_SINK_ERR_CHECK_EN` defined:
  - `error` is driven as specified;
  - the DISCARD state exists;
  - overflow drops the packet.
- Not defined:
  - `error` is tied to 0 and there is no DISCARD state;
  - words beyond MAX_LENGTH are silently dropped and the packet still completes on eop with `length`=MAX_LENGTH;
  - sop in RECV restarts silently;
  - valid without sop in IDLE is silently dropped.

## Structure
- Shared package `stream_pkg`:
  - FSM state enum (IDLE, RECV, DISCARD);
  - `LEN_W` derivation function;
  - word-slot index helper shared with the serializer.
- No sub-module. Assembly buffer, counter and FSM live in `stream_sink`.

## Test plan
- MAX_LENGTH=4, DATA_WIDTH=8: serializer drives 0x44,0x33,0x22,0x11 (sop on 0x44, eop on 0x11). Expected one cycle after eop: `data_out`=0x44332211, `length`=4, `out_valid` one pulse.
- Two-word packet 0xAA(sop),0xBB(eop) with two idle cycles between the words. Expected: `data_out`=0xAABB0000, `length`=2.
- Single beat 0x5C with sop&eop. Expected next cycle: `data_out`=0x5C000000, `length`=1.
- Overflow with macro on: 5 words, no eop within the first 4. Expected: `error` pulse after the 5th word, no `out_valid`, remaining words ignored until eop. A following valid packet is received correctly.
- sop in RECV after 2 words, then 0x01,0x02(eop). Expected: `error` pulse, then `data_out`=0x[sop-word]010200, `length`=3.
- Reset asserted after 2 words of a 4-word packet, then a full packet is sent. Expected: no output for the aborted packet, correct output for the new one.
